// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - memory port request/response/ready bundle between core memory side and pipe_ctrl
interface pipe_ctrl_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0] port_req;
    logic [NUM_PORTS-1:0] port_resp;
    logic [NUM_PORTS-1:0] port_ready;

    modport master (
        output port_req,
        output port_resp,
        input  port_ready
    );

    modport slave (
        input  port_req,
        input  port_resp,
        output port_ready
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - N-stage/P-port pipeline stall, flush and retire control
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int NUM_PORTS   = 2,
    parameter int HOLD_STAGES = 2,
    parameter int FLUSH_DEPTH = 2,
    parameter int ORDER_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_ctrl_if.slave            mem_if,
    input  logic                  hazard_stall_i,
    input  logic                  flush_req_i,
    output logic [NUM_STAGES-1:0] stage_we_o,
    output logic [NUM_STAGES-1:0] stage_bubble_o,
    input  logic                  retire_in_i,
    output logic                  retire_valid_o,
    output logic [ORDER_W-1:0]    retire_order_o,
    output logic [31:0]           perf_mem_stall_o,
    output logic [31:0]           perf_haz_stall_o,
    output logic [31:0]           perf_flush_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HELD = 2'd2
    } port_state_e;

    port_state_e          state_q [NUM_PORTS];
    port_state_e          state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] ready;
    logic                 advance;
    logic                 flush_eff;
    logic                 flush_pending_q, flush_pending_d;
    logic                 reported_q, reported_d;
    logic [ORDER_W-1:0]   order_q, order_d;

    // Per-port FSM: state register
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst) begin
                state_q[p] <= ST_IDLE;
            end else begin
                state_q[p] <= state_d[p];
            end
        end
    end

    // Per-port FSM: next state; a response is kept in HELD until the whole pipe advances
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                ST_IDLE: begin
                    if (mem_if.port_req[p]) begin
                        if (!mem_if.port_resp[p]) begin
                            state_d[p] = ST_WAIT;
                        end else if (!advance) begin
                            state_d[p] = ST_HELD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_if.port_resp[p]) begin
                        state_d[p] = advance ? ST_IDLE : ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (advance) begin
                        state_d[p] = ST_IDLE;
                    end
                end
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end

    // Per-port FSM: outputs
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            ready[p] = 1'b1;
            if (!rst) begin
                case (state_q[p])
                    ST_IDLE: ready[p] = !(mem_if.port_req[p] && !mem_if.port_resp[p]);
                    ST_WAIT: ready[p] = mem_if.port_resp[p];
                    ST_HELD: ready[p] = 1'b1;
                    default: ready[p] = 1'b1;
                endcase
            end
        end
    end

    assign mem_if.port_ready = ready;
    assign advance           = &ready;
    assign flush_eff         = flush_req_i | flush_pending_q;

    // A flush seen during a stall is remembered and applied on the advancing cycle only
    assign flush_pending_d = advance ? 1'b0 : (flush_pending_q | flush_req_i);

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_we_o[i]     = 1'b0;
            stage_bubble_o[i] = 1'b1;
            if (!rst) begin
                if (i < HOLD_STAGES) begin
                    stage_we_o[i] = advance & (flush_eff | !hazard_stall_i);
                end else begin
                    stage_we_o[i] = advance;
                end
                if (flush_eff) begin
                    stage_bubble_o[i] = (i >= 1) && (i <= FLUSH_DEPTH);
                end else begin
                    stage_bubble_o[i] = hazard_stall_i && (i == HOLD_STAGES);
                end
            end
        end
    end

    // Writeback holds its instruction across a stall; report it once
    assign retire_valid_o = retire_in_i & !reported_q & !rst;
    assign reported_d     = advance ? 1'b0 : (reported_q | retire_valid_o);
    assign order_d        = retire_valid_o ? order_q + ORDER_W'(1) : order_q;
    assign retire_order_o = order_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending_q <= 1'b0;
            reported_q      <= 1'b0;
            order_q         <= '0;
        end else begin
            flush_pending_q <= flush_pending_d;
            reported_q      <= reported_d;
            order_q         <= order_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_mem_q, perf_mem_d;
    logic [31:0] perf_haz_q, perf_haz_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    assign perf_mem_d   = sat_inc(perf_mem_q, !advance);
    assign perf_haz_d   = sat_inc(perf_haz_q, advance & hazard_stall_i & !flush_eff);
    assign perf_flush_d = sat_inc(perf_flush_q, advance & flush_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_q   <= '0;
            perf_haz_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_mem_q   <= perf_mem_d;
            perf_haz_q   <= perf_haz_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_mem_stall_o = perf_mem_q;
    assign perf_haz_stall_o = perf_haz_q;
    assign perf_flush_o     = perf_flush_q;
`else
    assign perf_mem_stall_o = 32'd0;
    assign perf_haz_stall_o = 32'd0;
    assign perf_flush_o     = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the rv32imc in-order core. It generalises the fixed 5-stage, 2-port stall logic into N stages and P memory ports. Each port gets a response-tracking state machine that keeps a response sticky until the whole pipe advances. The block also generates per-stage write-enable and bubble signals for hazard stall and branch flush, and produces a deduplicated retire strobe with a monotonic order counter for the RVFI monitor.

## Interface
- NUM_STAGES, 5, pipeline register count; stage 0 = PC/fetch, stage NUM_STAGES-1 = writeback.
- NUM_PORTS, 2, memory ports tracked (port 0 = imem, port 1 = dmem).
- HOLD_STAGES, 2, stages 0..HOLD_STAGES-1 hold on hazard stall; stage HOLD_STAGES receives a bubble.
- FLUSH_DEPTH, 2, stages 1..FLUSH_DEPTH are bubbled on flush; must be < NUM_STAGES.
- ORDER_W, 64, retire order width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- port_req  in  NUM_PORTS  request issued this cycle (mask non-zero).
- port_resp  in  NUM_PORTS  memory response.
- port_ready  out  NUM_PORTS  port has no pending request.
- hazard_stall  in  1  load-use stall from decode.
- flush_req  in  1  redirect from execute.
- stage_we  out  NUM_STAGES  stage register write enable.
- stage_bubble  out  NUM_STAGES  load an invalid bubble instead of the upstream value; only meaningful with stage_we.
- retire_in  in  1  writeback register holds a valid instruction.
- retire_valid  out  1  one-cycle strobe, once per instruction.
- retire_order  out  ORDER_W  order of the retiring instruction.
- perf_mem_stall, perf_haz_stall, perf_flush  out  32 each  performance counters.

## Operation
- Per-port FSM, states IDLE, WAIT, HELD:
  - IDLE:
    - !req gives ready=1.
    - req&resp gives ready=1; if !advance, go to HELD.
    - req&!resp gives ready=0 and goes to WAIT.
  - WAIT: ready=resp.
    - resp&advance goes to IDLE.
    - resp&!advance goes to HELD.
  - HELD: ready=1; port_resp and port_req are ignored; advance goes to IDLE.
- advance = &port_ready.
- flush_eff = flush_req | flush_pending.
  - flush_pending is set when flush_req & !advance.
  - flush_pending is cleared when advance.
- stage_we[i]:
  - i ≥ HOLD_STAGES: advance.
  - i < HOLD_STAGES: advance & (flush_eff | !hazard_stall).
- stage_bubble[i]:
  - i in 1..FLUSH_DEPTH when flush_eff.
  - i = HOLD_STAGES when hazard_stall & !flush_eff.
  - 0 otherwise.
  - Flush wins over hazard_stall.
- Retire:
  - retire_valid = retire_in & !reported & !rst.
  - reported is set on retire_valid & !advance and cleared on advance.
  - retire_order shows the current counter value; the counter increments by 1 on each retire_valid, wrapping modulo 2^ORDER_W.

## Timing
- Reset values:
  - FSMs IDLE, flush_pending 0, reported 0, order 0, perf counters 0.
  - During rst: stage_we all 0, stage_bubble all 1, port_ready all 1, retire_valid 0.
- port_ready, stage_we, stage_bubble and retire_valid are combinational from state and current inputs, with zero-cycle latency.
- Single-cycle memory (resp in the same cycle as req) causes no stall.
- Response arriving while another port waits: captured in HELD, no second response needed.
- Reset mid-WAIT: FSM returns to IDLE next cycle; late responses in IDLE without req are ignored.
- Flush during a memory stall: honoured on the advancing cycle only, exactly once.
- Simultaneous flush_req and hazard_stall: flush behaviour, stages 0..HOLD_STAGES-1 write.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_mem_stall counts cycles with !advance.
  - perf_haz_stall counts cycles with advance & hazard_stall & !flush_eff.
  - perf_flush counts advancing cycles with flush_eff.
  - All counters saturate at 32'hFFFF_FFFF.
- PIPE_CTRL_PERF_EN undefined: counter registers are not built and all three outputs are tied to 0.

## Test plan
- Defaults, port 0 req&resp every cycle, port 1 idle, retire_in=1 for 4 cycles:
  - stage_we=5'h1F each cycle.
  - retire_order = 0,1,2,3.
- Port 0 req at cycle 0 with resp at cycle 0; port 1 req at cycle 0 with resp at cycle 3:
  - port 0 is HELD for cycles 1-3.
  - advance only at cycle 3.
  - stage_we=0 for cycles 0-2.
  - perf_mem_stall=3.
- hazard_stall=1 for one advancing cycle:
  - stage_we=5'h1C.
  - stage_bubble[2]=1.
  - perf_haz_stall increments by 1.
- flush_req pulsed for one cycle while port 1 waits 2 more cycles:
  - on the advance cycle, stage_bubble=5'h06 and stage_we=5'h1F.
  - on the next cycle, no bubble.
  - perf_flush=1.
- retire_in held for 3 cycles during a memory stall:
  - a single retire_valid pulse.
  - order increments by exactly 1.
- rst asserted mid-WAIT, then late port_resp:
  - ports IDLE, ready=1.
  - order 0.
  - no spurious retire_valid or advance artefact.
